controller_input_conditioner: RTL and testbench

Sits directly upstream of the joystick/button controller stage. Takes the six raw Pmod inputs (left, right, up, down, attack, pery) and turns them into clean signals for the controller:
- synchronises each input into clk
- debounces each input with a per-channel stability counter
- emits registered level outputs and one-cycle press/release pulses.

---
 rtl/ctrl_pkg.sv | 17 +
 rtl/debounce_channel.sv | 54 +++++
 rtl/controller_input_conditioner.sv | 86 ++++++++
 tb/tb_controller_input_conditioner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the controller input conditioner: channel count,
// channel bit positions and the default debounce interval.
package ctrl_pkg;

  localparam int N_INPUTS = 6;

  localparam int IDX_LEFT   = 0;
  localparam int IDX_RIGHT  = 1;
  localparam int IDX_UP     = 2;
  localparam int IDX_DOWN   = 3;
  localparam int IDX_ATTACK = 4;
  localparam int IDX_PERY   = 5;

  // 10 ms at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// Single-input conditioner: polarity normalise, 2-FF synchroniser, and a
// stability counter that flips the stable bit after DEBOUNCE_CYCLES mismatches.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter bit INPUT_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          raw_norm;
  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          stable_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign raw_norm = INPUT_ACTIVE_LOW ? ~raw : raw;

  always_comb begin
    cnt_next    = cnt_reg + 1'b1;
    stable_next = stable_reg;
    if (sync2_reg == stable_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_MAX) begin
      stable_next = ~stable_reg;
      cnt_next    = '0;
    end
  end

  // Sync flops hold the normalised value, so 0 here is the inactive raw level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg  <= raw_norm;
      sync2_reg  <= sync1_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/controller_input_conditioner.sv
// Debounces the six Pmod controller inputs and produces registered levels plus
// press/release strobes. Define CTRL_SOCD_EN to neutralise opposing directions.
module controller_input_conditioner #(
  parameter int N_INPUTS         = ctrl_pkg::N_INPUTS,
  parameter int DEBOUNCE_CYCLES  = ctrl_pkg::DEFAULT_DEBOUNCE_CYCLES,
  parameter bit INPUT_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] raw_in,
  output logic [N_INPUTS-1:0] level_out,
  output logic [N_INPUTS-1:0] press_pulse,
  output logic [N_INPUTS-1:0] release_pulse,
  output logic                any_change
);

  import ctrl_pkg::*;

  logic [N_INPUTS-1:0] stable;
  logic [N_INPUTS-1:0] masked;
  logic [N_INPUTS-1:0] level_reg;
  logic [N_INPUTS-1:0] level_next;
  logic [N_INPUTS-1:0] press_reg;
  logic [N_INPUTS-1:0] press_next;
  logic [N_INPUTS-1:0] release_reg;
  logic [N_INPUTS-1:0] release_next;
  logic                any_change_reg;
  logic                any_change_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .INPUT_ACTIVE_LOW (INPUT_ACTIVE_LOW)
      ) u_chan (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_in[gi]),
        .stable (stable[gi])
      );
    end
  endgenerate

  always_comb begin
    masked = stable;
`ifdef CTRL_SOCD_EN
    // Opposing directions held together resolve to neutral.
    if (stable[IDX_LEFT] && stable[IDX_RIGHT]) begin
      masked[IDX_LEFT]  = 1'b0;
      masked[IDX_RIGHT] = 1'b0;
    end
    if (stable[IDX_UP] && stable[IDX_DOWN]) begin
      masked[IDX_UP]   = 1'b0;
      masked[IDX_DOWN] = 1'b0;
    end
`endif
  end

  always_comb begin
    level_next      = masked;
    press_next      = ~level_reg & masked;
    release_next    = level_reg & ~masked;
    any_change_next = |(press_next | release_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg      <= '0;
      press_reg      <= '0;
      release_reg    <= '0;
      any_change_reg <= 1'b0;
    end else begin
      level_reg      <= level_next;
      press_reg      <= press_next;
      release_reg    <= release_next;
      any_change_reg <= any_change_next;
    end
  end

  assign level_out     = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign any_change    = any_change_reg;

endmodule

// File: tb/tb_controller_input_conditioner.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a window-based behavioural model.
module tb_controller_input_conditioner;

  localparam int N = 6;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] raw_in;
  logic [N-1:0] level_out;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic         any_change;

  int checks = 0;
  int errors = 0;

  controller_input_conditioner #(
    .N_INPUTS         (N),
    .DEBOUNCE_CYCLES  (D),
    .INPUT_ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_in        (raw_in),
    .level_out     (level_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .any_change    (any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [N-1:0] msk(input logic [N-1:0] s);
    logic [N-1:0] r;
    r = s;
`ifdef CTRL_SOCD_EN
    if (s[0] && s[1]) r[1:0] = 2'b00;
    if (s[2] && s[3]) r[3:2] = 2'b00;
`endif
    return r;
  endfunction

  logic [N-1:0] m_s1, m_s2, m_stable, m_level, m_press, m_rel;
  logic         m_any;
  bit           m_valid = 1'b0;
  bit           hist [N][$];

  // Stable flips once the last D synchronised samples all disagree with it.
  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
      for (int c = 0; c < N; c++) hist[c].delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_press = ~m_level & msk(m_stable);
      m_rel   = m_level & ~msk(m_stable);
      m_any   = |(m_press | m_rel);
      m_level = msk(m_stable);
      for (int c = 0; c < N; c++) begin
        bit all_diff;
        hist[c].push_back(m_s2[c]);
        if (hist[c].size() > D) void'(hist[c].pop_front());
        all_diff = (hist[c].size() == D);
        foreach (hist[c][j]) if (hist[c][j] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) m_stable[c] = ~m_stable[c];
      end
      m_s2 = m_s1;
      m_s1 = ~raw_in;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_level",   32'(level_out),     32'(m_level));
      chk("cmp_press",   32'(press_pulse),   32'(m_press));
      chk("cmp_release", 32'(release_pulse), 32'(m_rel));
      chk("cmp_any",     32'(any_change),    32'(m_any));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] acc;
    int           n_press, n_rel;
    int           hold [N];

    raw_in = '1;
    reset  = 1'b1;
    #1;
    steps(3);
    chk("reset_level", 32'(level_out), 0);
    chk("reset_press", 32'(press_pulse), 0);
    chk("reset_release", 32'(release_pulse), 0);
    chk("reset_any", 32'(any_change), 0);
    reset = 1'b0;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc |= level_out | press_pulse | release_pulse | {N{any_change}};
    end
    chk("idle_after_reset", 32'(acc), 0);

    // Clean press on left
    raw_in[0] = 1'b0;
    step();                // edge k: captured in sync1
    steps(5);              // edge k+5
    chk("press_k5_level", 32'(level_out[0]), 0);
    step();                // edge k+6
    chk("press_k6_level", 32'(level_out[0]), 1);
    chk("press_k6_pulse", 32'(press_pulse[0]), 1);
    chk("press_k6_any", 32'(any_change), 1);
    step();
    chk("press_k7_pulse", 32'(press_pulse[0]), 0);
    chk("press_k7_level", 32'(level_out[0]), 1);

    // Release on left
    raw_in[0] = 1'b1;
    steps(6);
    chk("rel_k5_level", 32'(level_out[0]), 1);
    step();
    chk("rel_k6_level", 32'(level_out[0]), 0);
    chk("rel_k6_pulse", 32'(release_pulse[0]), 1);
    step();
    chk("rel_k7_pulse", 32'(release_pulse[0]), 0);

    // Glitch of 3 samples on attack is rejected
    raw_in[4] = 1'b0;
    steps(3);
    raw_in[4] = 1'b1;
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      acc |= level_out | press_pulse | release_pulse;
    end
    chk("glitch3_quiet", 32'(acc), 0);

    // 4 samples qualifies: exactly one press and one release
    raw_in[4] = 1'b0;
    steps(4);
    raw_in[4] = 1'b1;
    n_press = 0;
    n_rel   = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (press_pulse[4]) n_press++;
      if (release_pulse[4]) n_rel++;
    end
    chk("glitch4_press_count", 32'(n_press), 1);
    chk("glitch4_release_count", 32'(n_rel), 1);

    // Opposing directions: hold left, then press right
    raw_in[0] = 1'b0;
    steps(10);
    chk("socd_left_held", 32'(level_out[1:0]), 32'h1);
    raw_in[1] = 1'b0;
    steps(6);
    chk("socd_k5_level", 32'(level_out[1:0]), 32'h1);
    step();
`ifdef CTRL_SOCD_EN
    chk("socd_level", 32'(level_out[1:0]), 32'h0);
    chk("socd_release0", 32'(release_pulse[0]), 1);
    chk("socd_press1", 32'(press_pulse[1]), 0);
`else
    chk("socd_level", 32'(level_out[1:0]), 32'h3);
    chk("socd_press1", 32'(press_pulse[1]), 1);
    chk("socd_release0", 32'(release_pulse[0]), 0);
`endif
    raw_in = '1;
    steps(12);

    // Reset mid-count on up
    raw_in[2] = 1'b0;
    step();                // edge k
    steps(2);              // edge k+2
    reset = 1'b1;
    step();                // edge k+3 samples reset
    reset = 1'b0;
    step();                // first post-reset sync1 capture
    steps(5);
    chk("midrst_k5_level", 32'(level_out[2]), 0);
    step();
    chk("midrst_k6_level", 32'(level_out[2]), 1);
    chk("midrst_k6_press", 32'(press_pulse[2]), 1);
    raw_in = '1;
    steps(12);

    // Randomized run against the model
    for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 8);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          raw_in[c] = ~raw_in[c];
          hold[c]   = $urandom_range(1, 8);
        end
      end
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    steps(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
